// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes RxD, oversamples each bit, majority-votes
// three mid-bit samples and checks the stop bit before presenting the byte.
module uart_receiver #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned M   = OVERSAMPLE / 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_M_LO    = SW'(M - 1);
  localparam logic [SW-1:0] S_M       = SW'(M);
  localparam logic [SW-1:0] S_M_HI    = SW'(M + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s, rx_d;
  logic [TW-1:0] tick_cnt_q;
  logic [SW-1:0] s_q;
  logic [2:0]    smp_q;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_d;
  logic          valid_d, ferr_d;

  logic tick_c, start_edge_c, bit_end_c, stop_point_c, maj_stored_c, maj_live_c;

  assign tick_c       = (tick_cnt_q == TICK_LAST);
  assign start_edge_c = (state_q == IDLE) && rx_d && !rx_s;
  assign bit_end_c    = tick_c && (s_q == S_LAST);
  assign stop_point_c = tick_c && (s_q == S_M_HI);
  assign maj_stored_c = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  // Stop bit is judged on its third sample as it arrives, so use rx_s live.
  assign maj_live_c   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  // Input synchronizer and one-clock delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      sync1_q <= RxD;
      rx_s    <= sync1_q;
      rx_d    <= rx_s;
    end
  end

  // Tick generator, sample counter and mid-bit sample capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      s_q        <= '0;
      smp_q      <= 3'b111;
    end else if (start_edge_c) begin
      tick_cnt_q <= '0;
      s_q        <= '0;
    end else begin
      tick_cnt_q <= tick_c ? '0 : TW'(tick_cnt_q + TW'(1));
      if (tick_c) begin
        s_q <= (s_q == S_LAST) ? '0 : SW'(s_q + SW'(1));
        if (s_q == S_M_LO) smp_q[0] <= rx_s;
        if (s_q == S_M)    smp_q[1] <= rx_s;
        if (s_q == S_M_HI) smp_q[2] <= rx_s;
      end
    end
  end

  // Frame FSM: state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      data          <= data_d;
      data_valid    <= valid_d;
      framing_error <= ferr_d;
      busy          <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    data_d    = data;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: if (start_edge_c) state_d = START;
      START: begin
        if (bit_end_c) begin
          if (!maj_stored_c) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shift_d   = {maj_stored_c, shift_q[7:1]};
          bit_idx_d = 3'(bit_idx_q + 3'd1);
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (stop_point_c) begin
          if (maj_live_c) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, hand-written
// corner sequences and randomized frames against a byte-level reference model.
module tb_uart_receiver;

  localparam int unsigned BIT = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] data;
  logic       data_valid, framing_error, busy;

  int checks = 0;
  int failures = 0;
  int vcnt = 0, fcnt = 0, proto_err = 0;
  logic prev_v = 1'b0, prev_f = 1'b0;

  uart_receiver #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .data(data),
    .data_valid(data_valid), .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters plus exclusivity / single-cycle pulse watch
  always @(negedge clk) begin
    if (data_valid) vcnt++;
    if (framing_error) fcnt++;
    if ((data_valid && framing_error) || (data_valid && prev_v) || (framing_error && prev_f))
      proto_err++;
    prev_v = data_valid;
    prev_f = framing_error;
  end

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       noise;
    int         gap;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic noise, input int bl);
    drive(1'b0, 10);
    check("busy_after_start", 32'(busy), 32'd1);
    drive(1'b0, bl - 10);
    for (int i = 0; i < 8; i++) begin
      if (noise) begin
        drive(b[i], 88);
        drive(~b[i], 1);
        drive(b[i], bl - 89);
      end else begin
        drive(b[i], bl);
      end
    end
    drive(stop, bl);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic stop, input logic noise,
                           input int gap, input int bl, input int exp_v, input int exp_f,
                           input logic [7:0] exp_d);
    int v0, f0;
    if (gap > 0) drive(1'b1, gap);
    v0 = vcnt;
    f0 = fcnt;
    send_frame(b, stop, noise, bl);
    check({tag, "_valid_pulses"}, 32'(vcnt - v0), 32'(exp_v));
    check({tag, "_ferr_pulses"}, 32'(fcnt - f0), 32'(exp_f));
    check({tag, "_data"}, 32'(data), 32'(exp_d));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int v0, f0, bh;
    logic [7:0] model_data, rb;
    logic rstop, rnoise;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 50,  1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 50,  1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 0,   1, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 30,  1, 0, 8'h5A};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 40,  0, 1, 8'h5A};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 100, 1, 0, 8'hC3};
    vecs[6] = '{8'h01, 1'b0, 1'b0, 20,  0, 1, 8'hC3};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 20,  1, 0, 8'h80};

    reset = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_ferr", 32'(framing_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    drive(1'b1, 40);

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].b, vecs[i].stop, vecs[i].noise, vecs[i].gap, BIT,
                vecs[i].exp_v, vecs[i].exp_f, vecs[i].exp_d);

    // Start glitch: 40 clk low must be rejected, then a real frame follows
    drive(1'b1, 50);
    v0 = vcnt;
    f0 = fcnt;
    drive(1'b0, 40);
    drive(1'b1, 130);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_no_pulse", 32'(vcnt - v0 + fcnt - f0), 32'd0);
    run_frame("after_glitch", 8'h3C, 1'b1, 1'b0, 40, BIT, 1, 0, 8'h3C);

    // Framing error followed by a long break: no retrigger while stuck low
    drive(1'b1, 50);
    v0 = vcnt;
    f0 = fcnt;
    send_frame(8'h81, 1'b0, 1'b0, BIT);
    bh = 0;
    RxD = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) bh++;
    end
    check("break_ferr_pulses", 32'(fcnt - f0), 32'd1);
    check("break_valid_pulses", 32'(vcnt - v0), 32'd0);
    check("break_data_held", 32'(data), 32'h3C);
    check("break_busy_cycles", 32'(bh), 32'd0);
    run_frame("after_break", 8'h42, 1'b1, 1'b0, 100, BIT, 1, 0, 8'h42);

    // Reset in the middle of the data bits of 8'h77
    drive(1'b1, 50);
    v0 = vcnt;
    f0 = fcnt;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) begin
      rb = 8'h77;
      drive(rb[i], BIT);
    end
    reset = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_valid", 32'(data_valid), 32'h0);
    check("midrst_ferr", 32'(framing_error), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    RxD = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 2000);
    check("midrst_no_pulse", 32'(vcnt - v0 + fcnt - f0), 32'd0);
    run_frame("after_rst", 8'h12, 1'b1, 1'b0, 50, BIT, 1, 0, 8'h12);

    // Randomized frames with baud mismatch against the byte-level model
    model_data = 8'h12;
    for (int n = 0; n < 20; n++) begin
      rb     = 8'($urandom);
      rstop  = ($urandom_range(4, 0) != 0);
      rnoise = 1'($urandom);
      if (rstop) model_data = rb;
      run_frame($sformatf("rand%0d", n), rb, rstop, rnoise, int'($urandom_range(300, 20)),
                int'($urandom_range(163, 157)), rstop ? 1 : 0, rstop ? 0 : 1, model_data);
    end

    check("pulse_protocol", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
